cc_input_cond: RTL and testbench

CC_INPUT_COND -- requirements
Module: cc_input_cond

---
 rtl/cc_input_cond.sv | 237 +++++++++++++++++++++++
 tb/tb_cc_input_cond.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cc_input_cond.sv
// cc_input_cond
//   Conditions the player inputs of the core. It merges the USB/DB joysticks
//   with a PS/2 keyboard, debounces every control, applies SOCD neutral per
//   stick and shapes the coin input into one pulse that lasts a fixed number
//   of frames.
//
// Parameters
//   DEB_CYCLES  - consecutive clk_sys cycles a raw input must differ from its
//                 debounced value before the debounced value follows it
//   COIN_FRAMES - coin1 pulse width, counted in vblank rising edges
//
// Ports
//   clk_sys     in   system clock; all logic runs on its rising edge
//   reset       in   synchronous, active-high reset
//   vblank      in   vertical blank level, synchronous to clk_sys
//   ps2_key     in   [10] event toggle, [9] pressed, [8] extended, [7:0] code
//   joystick_0  in   player 1: [0]R [1]L [2]D [3]U [4]RR [5]RL [6]RD [7]RU
//                    [8]Start1 [9]Start2 [10]Coin
//   joystick_1  in   player 2, same layout
//   p1_ctl      out  debounced player 1 sticks, joystick bit order [7:0]
//   p2_ctl      out  debounced player 2 sticks, joystick bit order [7:0]
//   start1      out  debounced start 1 level
//   start2      out  debounced start 2 level
//   coin1       out  coin pulse, COIN_FRAMES frames wide
module cc_input_cond #(
  parameter int DEB_CYCLES  = 4800,
  parameter int COIN_FRAMES = 3
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        vblank,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  output logic [7:0]  p1_ctl,
  output logic [7:0]  p2_ctl,
  output logic        start1,
  output logic        start2,
  output logic        coin1
);

  localparam int NUM_RAW = 19;
  localparam int CNT_W   = (DEB_CYCLES < 1) ? 1 : $clog2(DEB_CYCLES + 1);
  localparam int FRM_W   = (COIN_FRAMES < 1) ? 1 : $clog2(COIN_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(COIN_FRAMES - 1);

  // Key-state slots: [7:0] mirror the stick bits, then start1, start2, coin.
  localparam int KEY_START1 = 8;
  localparam int KEY_START2 = 9;
  localparam int KEY_COIN   = 10;

  // Raw/debounced vector: [7:0] p1 sticks, [15:8] p2 sticks, then starts, coin.
  localparam int RAW_START1 = 16;
  localparam int RAW_START2 = 17;
  localparam int RAW_COIN   = 18;

  typedef enum logic [1:0] {
    COIN_IDLE  = 2'd0,
    COIN_PULSE = 2'd1,
    COIN_HOLD  = 2'd2
  } coin_state_e;

  logic [10:0]        key_q, key_d;
  logic               kbd_tog_q, kbd_tog_d;
  logic               key_event;
  logic [NUM_RAW-1:0] raw;
  logic               raw_start1, raw_start2;
  logic [NUM_RAW-1:0] deb_q, deb_d;
  logic [CNT_W-1:0]   cnt_q [NUM_RAW];
  logic [CNT_W-1:0]   cnt_d [NUM_RAW];
  logic [7:0]         p1_ctl_q, p1_ctl_d;
  logic [7:0]         p2_ctl_q, p2_ctl_d;
  logic               start1_q, start1_d;
  logic               start2_q, start2_d;
  logic               vblank_q, vblank_d;
  logic               coin_prev_q, coin_prev_d;
  logic               vblank_rise, coin_rise;
  coin_state_e        coin_state_q, coin_state_d;
  logic [FRM_W-1:0]   frame_q, frame_d;
  logic               coin1_q, coin1_d;
  logic               unused_joy_bits;

  assign unused_joy_bits = ^{joystick_0[15:11], joystick_1[15:11]};

  // Opposing directions cancel: bit order is U=3, D=2, L=1, R=0.
  function automatic logic [3:0] socd_neutral(input logic [3:0] dirs);
    logic [3:0] res;
    res = dirs;
    if (dirs[3] && dirs[2]) res[3:2] = 2'b00;
    if (dirs[1] && dirs[0]) res[1:0] = 2'b00;
    return res;
  endfunction

  // A keyboard event is any change of the toggle bit; the extended flag only
  // matters for the start/coin codes, the arrows and WASD accept both forms.
  always_comb begin
    key_d     = key_q;
    kbd_tog_d = ps2_key[10];
    key_event = (ps2_key[10] != kbd_tog_q);
    if (key_event) begin
      case (ps2_key[7:0])
        8'h75:        key_d[7] = ps2_key[9];
        8'h72:        key_d[6] = ps2_key[9];
        8'h6B:        key_d[5] = ps2_key[9];
        8'h74:        key_d[4] = ps2_key[9];
        8'h1D:        key_d[3] = ps2_key[9];
        8'h1B:        key_d[2] = ps2_key[9];
        8'h1C:        key_d[1] = ps2_key[9];
        8'h23:        key_d[0] = ps2_key[9];
        8'h05, 8'h16: if (!ps2_key[8]) key_d[KEY_START1] = ps2_key[9];
        8'h06, 8'h1E: if (!ps2_key[8]) key_d[KEY_START2] = ps2_key[9];
        8'h2E, 8'h36: if (!ps2_key[8]) key_d[KEY_COIN]   = ps2_key[9];
        default:      ;
      endcase
    end
  end

  // Pressing start also inserts a coin, so raw coin includes both starts.
  always_comb begin
    raw_start1 = joystick_0[8] | joystick_1[8] | key_q[KEY_START1];
    raw_start2 = joystick_0[9] | joystick_1[9] | key_q[KEY_START2];
    raw        = '0;
    raw[7:0]   = joystick_0[7:0] | key_q[7:0];
    raw[15:8]  = joystick_1[7:0];
    raw[RAW_START1] = raw_start1;
    raw[RAW_START2] = raw_start2;
    raw[RAW_COIN]   = joystick_0[10] | joystick_1[10] | key_q[KEY_COIN]
                      | raw_start1 | raw_start2;
  end

  // The counter reaching CNT_LAST while still different is the DEB_CYCLES-th
  // differing cycle, so the debounced value flips on that same edge.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < NUM_RAW; i++) begin
      cnt_d[i] = '0;
      if (raw[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = raw[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    p1_ctl_d    = {socd_neutral(deb_q[7:4]), socd_neutral(deb_q[3:0])};
    p2_ctl_d    = {socd_neutral(deb_q[15:12]), socd_neutral(deb_q[11:8])};
    start1_d    = deb_q[RAW_START1];
    start2_d    = deb_q[RAW_START2];
    vblank_d    = vblank;
    coin_prev_d = deb_q[RAW_COIN];
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      key_q       <= '0;
      kbd_tog_q   <= ps2_key[10];
      deb_q       <= '0;
      cnt_q       <= '{default: '0};
      p1_ctl_q    <= '0;
      p2_ctl_q    <= '0;
      start1_q    <= 1'b0;
      start2_q    <= 1'b0;
      vblank_q    <= 1'b0;
      coin_prev_q <= 1'b0;
    end else begin
      key_q       <= key_d;
      kbd_tog_q   <= kbd_tog_d;
      deb_q       <= deb_d;
      cnt_q       <= cnt_d;
      p1_ctl_q    <= p1_ctl_d;
      p2_ctl_q    <= p2_ctl_d;
      start1_q    <= start1_d;
      start2_q    <= start2_d;
      vblank_q    <= vblank_d;
      coin_prev_q <= coin_prev_d;
    end
  end

  // A vblank edge seen in the cycle that enters PULSE is not counted, because
  // frame counting only happens once the state register holds PULSE. Coin
  // activity during PULSE is ignored; HOLD waits for the coin to be released.
  always_comb begin
    coin_state_d = coin_state_q;
    frame_d      = frame_q;
    vblank_rise  = vblank & ~vblank_q;
    coin_rise    = deb_q[RAW_COIN] & ~coin_prev_q;
    case (coin_state_q)
      COIN_IDLE: begin
        if (coin_rise) begin
          coin_state_d = COIN_PULSE;
          frame_d      = '0;
        end
      end
      COIN_PULSE: begin
        if (vblank_rise) begin
          if (frame_q == FRM_LAST) begin
            coin_state_d = COIN_HOLD;
            frame_d      = '0;
          end else begin
            frame_d = frame_q + FRM_W'(1);
          end
        end
      end
      COIN_HOLD: begin
        if (!deb_q[RAW_COIN]) coin_state_d = COIN_IDLE;
      end
      default: begin
        coin_state_d = COIN_IDLE;
        frame_d      = '0;
      end
    endcase
    coin1_d = (coin_state_d == COIN_PULSE);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      coin_state_q <= COIN_IDLE;
      frame_q      <= '0;
      coin1_q      <= 1'b0;
    end else begin
      coin_state_q <= coin_state_d;
      frame_q      <= frame_d;
      coin1_q      <= coin1_d;
    end
  end

  assign p1_ctl = p1_ctl_q;
  assign p2_ctl = p2_ctl_q;
  assign start1 = start1_q;
  assign start2 = start2_q;
  assign coin1  = coin1_q;

endmodule

// File: tb/tb_cc_input_cond.sv
// tb_cc_input_cond
//   Directed bench for cc_input_cond with DEB_CYCLES=4, COIN_FRAMES=3.
//   A behavioural reference keeps the expected outputs from the input rules
//   (sample history for debounce, flags for the coin pulse) and is compared
//   with the DUT on every negative clock edge; directed sequences add
//   hand-counted latency and pulse-count expectations.
module tb_cc_input_cond;

  localparam int DEB       = 4;
  localparam int CF        = 3;
  localparam int VB_PERIOD = 12;
  localparam int VB_HIGH   = 3;

  logic        clk_sys;
  logic        reset;
  logic        vblank;
  logic [10:0] ps2_key;
  logic [15:0] joystick_0;
  logic [15:0] joystick_1;
  logic [7:0]  p1_ctl;
  logic [7:0]  p2_ctl;
  logic        start1;
  logic        start2;
  logic        coin1;

  int   checks   = 0;
  int   failures = 0;
  logic kb_tog;

  cc_input_cond #(
    .DEB_CYCLES (DEB),
    .COIN_FRAMES(CF)
  ) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .vblank    (vblank),
    .ps2_key   (ps2_key),
    .joystick_0(joystick_0),
    .joystick_1(joystick_1),
    .p1_ctl    (p1_ctl),
    .p2_ctl    (p2_ctl),
    .start1    (start1),
    .start2    (start2),
    .coin1     (coin1)
  );

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  // Free-running vblank, changed 2 time units after the edge so that the
  // directed loops can read it at the negedge without racing the stimulus.
  initial begin : vblank_gen
    int phase;
    phase  = 0;
    vblank = 1'b0;
    forever begin
      @(posedge clk_sys);
      #2;
      phase  = (phase + 1) % VB_PERIOD;
      vblank = (phase < VB_HIGH);
    end
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] simulation did not finish in time");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t",
               name, actual, expected, $time);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] j0, input logic [15:0] j1);
    @(posedge clk_sys);
    #1;
    joystick_0 = j0;
    joystick_1 = j1;
  endtask

  task automatic pressKey(input logic [7:0] code, input logic ext,
                          input logic pressed);
    @(posedge clk_sys);
    #1;
    kb_tog  = ~kb_tog;
    ps2_key = {kb_tog, pressed, ext, code};
  endtask

  task automatic waitCoin(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk_sys);
      if (coin1 === 1'b1) ok = 1'b1;
    end
    checkOutput("coin_pulse_seen", 32'(ok), 32'd1);
  endtask

  // Holds joystick_0 coin for n cycles, counting pulses and the vblank rising
  // edges that fall while coin1 is high.
  task automatic coinHold(input int n, output int pulses, output int rises);
    logic pv, pc;
    applyStimulus(16'h0400, 16'h0000);
    pv     = vblank;
    pc     = coin1;
    pulses = 0;
    rises  = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk_sys);
      if (c == 4) checkOutput("coin_latency_lo", 32'(coin1), 32'd0);
      if (c == 5) checkOutput("coin_latency_hi", 32'(coin1), 32'd1);
      if (coin1 && !pc) pulses++;
      if (coin1 && vblank && !pv) rises++;
      pv = vblank;
      pc = coin1;
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int key_slot(input logic [7:0] code, input logic ext);
    case (code)
      8'h75: return 7;
      8'h72: return 6;
      8'h6B: return 5;
      8'h74: return 4;
      8'h1D: return 3;
      8'h1B: return 2;
      8'h1C: return 1;
      8'h23: return 0;
      8'h05, 8'h16: return ext ? -1 : 8;
      8'h06, 8'h1E: return ext ? -1 : 9;
      8'h2E, 8'h36: return ext ? -1 : 10;
      default: return -1;
    endcase
  endfunction

  function automatic logic [3:0] neutral(input logic [3:0] s);
    logic [3:0] r;
    r = s;
    if (s[3] && s[2]) r[3:2] = 2'b00;
    if (s[1] && s[0]) r[1:0] = 2'b00;
    return r;
  endfunction

  logic [10:0] m_keys;
  logic        m_toggle;
  logic [18:0] m_deb;
  logic        m_coin_prev;
  logic        m_vb_prev;
  bit          m_pulsing;
  bit          m_waiting;
  int          m_frames;
  logic [18:0] hist[$];
  logic [18:0] e_vec;
  bit          m_valid = 1'b0;

  // e_vec = {p1_ctl, p2_ctl, start1, start2, coin1} expected after each edge.
  always @(posedge clk_sys) begin : ref_model
    logic [18:0] raw;
    logic [18:0] nd;
    logic        s1r, s2r;
    bit          vbr, crise, all_diff;
    int          slot;
    if (reset) begin
      m_keys      = '0;
      m_toggle    = ps2_key[10];
      m_deb       = '0;
      m_coin_prev = 1'b0;
      m_vb_prev   = 1'b0;
      m_pulsing   = 1'b0;
      m_waiting   = 1'b0;
      m_frames    = 0;
      hist.delete();
      e_vec       = '0;
      m_valid     = 1'b1;
    end else begin
      s1r = joystick_0[8] | joystick_1[8] | m_keys[8];
      s2r = joystick_0[9] | joystick_1[9] | m_keys[9];
      raw = {joystick_0[10] | joystick_1[10] | m_keys[10] | s1r | s2r,
             s2r, s1r, joystick_1[7:0], joystick_0[7:0] | m_keys[7:0]};

      vbr   = vblank && !m_vb_prev;
      crise = m_deb[18] && !m_coin_prev;
      if (m_pulsing) begin
        if (vbr) m_frames++;
        if (m_frames == CF) begin
          m_pulsing = 1'b0;
          m_waiting = 1'b1;
        end
      end else if (m_waiting) begin
        if (!m_deb[18]) m_waiting = 1'b0;
      end else if (crise) begin
        m_pulsing = 1'b1;
        m_frames  = 0;
      end

      e_vec = {neutral(m_deb[7:4]), neutral(m_deb[3:0]),
               neutral(m_deb[15:12]), neutral(m_deb[11:8]),
               m_deb[16], m_deb[17], m_pulsing};
      m_coin_prev = m_deb[18];
      m_vb_prev   = vblank;

      // Debounced value follows an input once the last DEB samples all differ.
      hist.push_back(raw);
      if (hist.size() > DEB) void'(hist.pop_front());
      nd = m_deb;
      if (hist.size() == DEB) begin
        for (int i = 0; i < 19; i++) begin
          all_diff = 1'b1;
          foreach (hist[k]) if (hist[k][i] == m_deb[i]) all_diff = 1'b0;
          if (all_diff) nd[i] = raw[i];
        end
      end
      m_deb = nd;

      if (ps2_key[10] != m_toggle) begin
        slot = key_slot(ps2_key[7:0], ps2_key[8]);
        if (slot >= 0) m_keys[slot] = ps2_key[9];
      end
      m_toggle = ps2_key[10];
    end
  end

  always @(negedge clk_sys) begin : compare
    if (m_valid)
      checkOutput("cycle_outputs",
                  32'({p1_ctl, p2_ctl, start1, start2, coin1}), 32'(e_vec));
  end

  // ---------------- directed sequences ----------------
  initial begin : stimulus
    int pulses, rises;
    bit ok;
    reset      = 1'b1;
    ps2_key    = '0;
    kb_tog     = 1'b0;
    joystick_0 = '0;
    joystick_1 = '0;
    waitCycles(3);
    @(negedge clk_sys);
    checkOutput("reset_state", 32'({p1_ctl, p2_ctl, start1, start2, coin1}), 32'd0);
    waitCycles(1);
    reset = 1'b0;
    waitCycles(4);

    $display("[TB] stick latency and glitch rejection");
    applyStimulus(16'h0008, 16'h0000);
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk_sys);
      checkOutput("p1_up_latency", 32'(p1_ctl[3]), 32'(k >= 5));
    end
    waitCycles(4);
    applyStimulus(16'h0000, 16'h0000);
    waitCycles(8);
    applyStimulus(16'h0004, 16'h0000);
    waitCycles(2);
    applyStimulus(16'h0000, 16'h0000);
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk_sys);
      checkOutput("p1_glitch", 32'(p1_ctl[2]), 32'd0);
    end
    waitCycles(2);

    $display("[TB] keyboard start and arrows");
    pressKey(8'h16, 1'b0, 1'b1);
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk_sys);
      checkOutput("kbd_start1_latency", 32'(start1), 32'(k >= 6));
    end
    pressKey(8'h16, 1'b0, 1'b0);
    waitCycles(60);
    pressKey(8'h16, 1'b1, 1'b1);
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk_sys);
      checkOutput("kbd_ext_start1_ignored", 32'(start1), 32'd0);
    end
    pressKey(8'h16, 1'b1, 1'b0);
    pressKey(8'h75, 1'b1, 1'b1);
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk_sys);
      checkOutput("kbd_ext_up", 32'(p1_ctl[7]), 32'(k >= 6));
    end
    pressKey(8'h75, 1'b1, 1'b0);
    waitCycles(8);

    $display("[TB] player 2 SOCD");
    applyStimulus(16'h0000, 16'h0003);
    waitCycles(9);
    @(negedge clk_sys);
    checkOutput("p2_socd_both", 32'(p2_ctl[1:0]), 32'd0);
    applyStimulus(16'h0000, 16'h0001);
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk_sys);
      checkOutput("p2_socd_release", 32'(p2_ctl[1:0]), (k >= 5) ? 32'd1 : 32'd0);
    end
    applyStimulus(16'h0000, 16'h0000);
    waitCycles(8);

    $display("[TB] coin pulse width");
    coinHold(240, pulses, rises);
    checkOutput("coin_one_pulse", 32'(pulses), 32'd1);
    checkOutput("coin_frames", 32'(rises), 32'd3);
    applyStimulus(16'h0000, 16'h0000);
    waitCycles(20);
    coinHold(120, pulses, rises);
    checkOutput("coin_second_pulse", 32'(pulses), 32'd1);
    checkOutput("coin_second_frames", 32'(rises), 32'd3);
    applyStimulus(16'h0000, 16'h0000);
    waitCycles(20);

    $display("[TB] coin released during pulse");
    applyStimulus(16'h0400, 16'h0000);
    waitCoin(ok);
    applyStimulus(16'h0000, 16'h0000);
    waitCycles(60);
    @(negedge clk_sys);
    checkOutput("coin_release_in_pulse", 32'(coin1), 32'd0);

    $display("[TB] reset during pulse");
    applyStimulus(16'h0400, 16'h0000);
    waitCoin(ok);
    @(posedge clk_sys);
    #1;
    reset      = 1'b1;
    joystick_0 = '0;
    kb_tog     = ~kb_tog;
    ps2_key    = {kb_tog, 1'b1, 1'b0, 8'h75};
    @(negedge clk_sys);
    checkOutput("coin_before_reset", 32'(coin1), 32'd1);
    @(negedge clk_sys);
    checkOutput("coin_reset_drop", 32'(coin1), 32'd0);
    checkOutput("reset_outputs_clear",
                32'({p1_ctl, p2_ctl, start1, start2}), 32'd0);
    waitCycles(1);
    reset = 1'b0;
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk_sys);
      checkOutput("no_key_after_reset", 32'(p1_ctl), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
